// File: rtl/enc4x2_req_encoder_pkg.sv
// ---------------------------------------------------------------------------
// enc4x2_req_encoder_pkg
// Shared definitions for the registered 4-to-2 request encoder.
//   N_REQ      : number of request lines
//   CODE_W     : width of the binary index presented to the consumer
//   state_e    : handshake FSM state encoding (IDLE / PRESENT)
//   LAST_RST   : reset value of the round-robin pointer, chosen so the
//                first round-robin scan after reset starts at line 0
// ---------------------------------------------------------------------------
package enc4x2_req_encoder_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam logic [CODE_W-1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/enc4x2_req_encoder_pri_enc4.sv
// ---------------------------------------------------------------------------
// pri_enc4
// Combinational selector for the request encoder.
// Ports:
//   pend  [3:0] in  : registered pending bits
//   start [1:0] in  : first index to examine in round-robin mode
//   rr          in  : 0 = fixed priority (highest index wins),
//                     1 = round-robin scan ascending from start, wrapping
//   idx   [1:0] out : selected index (0 when nothing is pending)
//   any         out : at least one pending bit is set
// ---------------------------------------------------------------------------
module pri_enc4
  import enc4x2_req_encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  pend,
  input  logic [CODE_W-1:0] start,
  input  logic              rr,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [CODE_W-1:0] pos;

  // Both scans are written so the winning candidate is the last one
  // assigned: ascending for fixed priority (highest index wins) and
  // descending distance from start for round-robin (nearest wins).
  always_comb begin
    idx = '0;
    pos = '0;
    any = |pend;
    if (!rr) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i]) idx = i[CODE_W-1:0];
      end
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        pos = start + k[CODE_W-1:0];
        if (pend[pos]) idx = pos;
      end
    end
  end

endmodule

// File: rtl/enc4x2_req_encoder.sv
// ---------------------------------------------------------------------------
// enc4x2_req_encoder
// Registered 4-to-2 request encoder. Request pulses are collected into
// pending bits; one pending line at a time is presented as a binary index
// over a valid/ack handshake. Fixed or round-robin priority, sticky
// per-line overrun flags.
// Parameters:
//   RR          : 0 = fixed priority (3 > 2 > 1 > 0), 1 = round-robin
// Ports:
//   clk           in  : clock, rising edge
//   rst           in  : synchronous active-high reset
//   req     [3:0] in  : request pulses/levels, sampled every edge
//   ack           in  : consumer accepts code (ignored while valid = 0)
//   ovr_clr       in  : clears all overrun flags
//   code    [1:0] out : index of the granted line
//   valid         out : code is presented and stable
//   pend    [3:0] out : current pending bits
//   overrun [3:0] out : sticky per-line overrun flags
// ---------------------------------------------------------------------------
module enc4x2_req_encoder
  import enc4x2_req_encoder_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  input  logic              ovr_clr,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pend,
  output logic [N_REQ-1:0]  overrun
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] last_q, last_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [N_REQ-1:0]  ovr_q, ovr_d;

  logic [N_REQ-1:0]  clr_mask;
  logic [N_REQ-1:0]  ovr_set;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_any;
  logic [CODE_W-1:0] rr_start;

  // Pointer increment is 2-bit modulo, so 3 wraps to 0.
  assign rr_start = last_q + 2'd1;

  pri_enc4 u_sel (
    .pend  (pend_q),
    .start (rr_start),
    .rr    (RR),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // A line is only cleared by an accepted handshake. A request landing on
  // the same edge as its own clear re-arms the line and is a fresh event,
  // so it is excluded from the overrun condition. A new overrun beats
  // ovr_clr for that bit.
  always_comb begin
    clr_mask = '0;
    if (valid_q && ack) clr_mask = N_REQ'(1) << code_q;
    pend_d  = (pend_q & ~clr_mask) | req;
    ovr_set = req & pend_q & ~clr_mask;
    ovr_d   = (ovr_clr ? '0 : ovr_q) | ovr_set;
  end

  // Handshake FSM. IDLE looks only at registered pend, which enforces the
  // one idle cycle between grants after an ack clears a line.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          code_d  = sel_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (RR) last_d = code_q;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset overrides every other input on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= LAST_RST;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pend    = pend_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_enc4x2_req_encoder.sv
// ---------------------------------------------------------------------------
// tb_enc4x2_req_encoder
// Directed bench: one fixed-priority instance (fx) and one round-robin
// instance (rr) share clock and reset but have independent handshakes.
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, so each tick shows the effect of exactly one edge.
// ---------------------------------------------------------------------------
module tb_enc4x2_req_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_fx, req_rr;
  logic       ack_fx, ack_rr;
  logic       ovr_clr_fx, ovr_clr_rr;
  logic [1:0] code_fx, code_rr;
  logic       valid_fx, valid_rr;
  logic [3:0] pend_fx, pend_rr;
  logic [3:0] overrun_fx, overrun_rr;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  enc4x2_req_encoder #(.RR(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .req(req_fx), .ack(ack_fx), .ovr_clr(ovr_clr_fx),
    .code(code_fx), .valid(valid_fx), .pend(pend_fx), .overrun(overrun_fx)
  );

  enc4x2_req_encoder #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req_rr), .ack(ack_rr), .ovr_clr(ovr_clr_rr),
    .code(code_rr), .valid(valid_rr), .pend(pend_rr), .overrun(overrun_rr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_fx = 4'b0; ack_fx = 1'b0; ovr_clr_fx = 1'b0;
    req_rr = 4'b0; ack_rr = 1'b0; ovr_clr_rr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_fx = 4'b1111; req_rr = 4'b1111;
    ack_fx = 1'b0; ack_rr = 1'b0; ovr_clr_fx = 1'b0; ovr_clr_rr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    req_fx = 4'b0; req_rr = 4'b0;
    vec_count++;
    if ({code_fx, valid_fx, pend_fx, overrun_fx} !== 11'd0) begin
      err_count++;
      $display("[TB] FAIL reset_fx: got code=%0d valid=%b pend=%b ovr=%b, need all 0", code_fx, valid_fx, pend_fx, overrun_fx);
    end
    vec_count++;
    if ({code_rr, valid_rr, pend_rr, overrun_rr} !== 11'd0) begin
      err_count++;
      $display("[TB] FAIL reset_rr: got code=%0d valid=%b pend=%b ovr=%b, need all 0", code_rr, valid_rr, pend_rr, overrun_rr);
    end
    tick(); tick();
    vec_count++;
    if (valid_fx !== 1'b0 || pend_fx !== 4'b0) begin
      err_count++;
      $display("[TB] FAIL idle_fx: got valid=%b pend=%b, need 0/0000", valid_fx, pend_fx);
    end
    vec_count++;
    if (valid_rr !== 1'b0 || pend_rr !== 4'b0) begin
      err_count++;
      $display("[TB] FAIL idle_rr: got valid=%b pend=%b, need 0/0000", valid_rr, pend_rr);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req_fx = 4'b0101;
    tick();
    req_fx = 4'b0;
    vec_count++;
    if (valid_fx !== 1'b0 || pend_fx !== 4'b0101) begin
      err_count++;
      $display("[TB] FAIL fix_latch: got valid=%b pend=%b, need 0/0101", valid_fx, pend_fx);
    end
    tick();
    vec_count++;
    if (valid_fx !== 1'b1 || code_fx !== 2'd2) begin
      err_count++;
      $display("[TB] FAIL fix_first: got valid=%b code=%0d, need 1/2", valid_fx, code_fx);
    end
    ack_fx = 1'b1;
    tick();
    ack_fx = 1'b0;
    vec_count++;
    if (valid_fx !== 1'b0 || pend_fx !== 4'b0001) begin
      err_count++;
      $display("[TB] FAIL fix_ack1: got valid=%b pend=%b, need 0/0001", valid_fx, pend_fx);
    end
    tick();
    vec_count++;
    if (valid_fx !== 1'b1 || code_fx !== 2'd0) begin
      err_count++;
      $display("[TB] FAIL fix_second: got valid=%b code=%0d, need 1/0", valid_fx, code_fx);
    end
    ack_fx = 1'b1;
    tick();
    ack_fx = 1'b0;
    vec_count++;
    if (valid_fx !== 1'b0 || pend_fx !== 4'b0000) begin
      err_count++;
      $display("[TB] FAIL fix_ack2: got valid=%b pend=%b, need 0/0000", valid_fx, pend_fx);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_rr = 4'b1111;
    tick(); tick();
    for (int j = 0; j < 5; j++) begin
      vec_count++;
      if (valid_rr !== 1'b1 || code_rr !== exp_seq[j]) begin
        err_count++;
        $display("[TB] FAIL rr_grant%0d: got valid=%b code=%0d, need 1/%0d", j, valid_rr, code_rr, exp_seq[j]);
      end
      ack_rr = 1'b1;
      tick();
      ack_rr = 1'b0;
      vec_count++;
      if (valid_rr !== 1'b0) begin
        err_count++;
        $display("[TB] FAIL rr_drop%0d: got valid=%b, need 0", j, valid_rr);
      end
      tick();
    end
    vec_count++;
    if (overrun_rr !== 4'b1111) begin
      err_count++;
      $display("[TB] FAIL rr_overrun: got %b, need 1111", overrun_rr);
    end
    req_rr = 4'b0;
  endtask

  task automatic test_clear_rerequest();
    do_reset();
    req_fx = 4'b0010;
    tick();
    req_fx = 4'b0;
    tick();
    vec_count++;
    if (valid_fx !== 1'b1 || code_fx !== 2'd1) begin
      err_count++;
      $display("[TB] FAIL rereq_present: got valid=%b code=%0d, need 1/1", valid_fx, code_fx);
    end
    ack_fx = 1'b1; req_fx = 4'b0010;
    tick();
    ack_fx = 1'b0; req_fx = 4'b0;
    vec_count++;
    if (valid_fx !== 1'b0 || pend_fx !== 4'b0010 || overrun_fx !== 4'b0) begin
      err_count++;
      $display("[TB] FAIL rereq_edge: got valid=%b pend=%b ovr=%b, need 0/0010/0000", valid_fx, pend_fx, overrun_fx);
    end
    tick();
    vec_count++;
    if (valid_fx !== 1'b1 || code_fx !== 2'd1) begin
      err_count++;
      $display("[TB] FAIL rereq_again: got valid=%b code=%0d, need 1/1", valid_fx, code_fx);
    end
    ack_fx = 1'b1;
    tick();
    ack_fx = 1'b0;
    vec_count++;
    if (pend_fx !== 4'b0) begin
      err_count++;
      $display("[TB] FAIL rereq_drain: got pend=%b, need 0000", pend_fx);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    req_fx = 4'b1000;
    tick();
    vec_count++;
    if (pend_fx !== 4'b1000 || overrun_fx !== 4'b0) begin
      err_count++;
      $display("[TB] FAIL ovr_first: got pend=%b ovr=%b, need 1000/0000", pend_fx, overrun_fx);
    end
    tick();
    req_fx = 4'b0;
    vec_count++;
    if (overrun_fx !== 4'b1000 || valid_fx !== 1'b1 || code_fx !== 2'd3) begin
      err_count++;
      $display("[TB] FAIL ovr_set: got ovr=%b valid=%b code=%0d, need 1000/1/3", overrun_fx, valid_fx, code_fx);
    end
    ovr_clr_fx = 1'b1; req_fx = 4'b1000;
    tick();
    req_fx = 4'b0;
    vec_count++;
    if (overrun_fx !== 4'b1000) begin
      err_count++;
      $display("[TB] FAIL ovr_setwins: got %b, need 1000", overrun_fx);
    end
    tick();
    ovr_clr_fx = 1'b0;
    vec_count++;
    if (overrun_fx !== 4'b0000) begin
      err_count++;
      $display("[TB] FAIL ovr_clear: got %b, need 0000", overrun_fx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Move the rr pointer away from its reset value by granting line 0.
    req_rr = 4'b0001;
    tick();
    req_rr = 4'b0;
    tick();
    ack_rr = 1'b1;
    tick();
    ack_rr = 1'b0;
    req_fx = 4'b0100; req_rr = 4'b0010;
    tick();
    req_fx = 4'b0; req_rr = 4'b0;
    tick();
    vec_count++;
    if (valid_fx !== 1'b1 || code_fx !== 2'd2) begin
      err_count++;
      $display("[TB] FAIL mid_pre_fx: got valid=%b code=%0d, need 1/2", valid_fx, code_fx);
    end
    vec_count++;
    if (valid_rr !== 1'b1 || code_rr !== 2'd1) begin
      err_count++;
      $display("[TB] FAIL mid_pre_rr: got valid=%b code=%0d, need 1/1", valid_rr, code_rr);
    end
    rst = 1'b1;
    ack_fx = 1'b1; ack_rr = 1'b1;
    req_fx = 4'b1111; req_rr = 4'b1111;
    ovr_clr_fx = 1'b1; ovr_clr_rr = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    vec_count++;
    if ({code_fx, valid_fx, pend_fx, overrun_fx} !== 11'd0) begin
      err_count++;
      $display("[TB] FAIL mid_rst_fx: got code=%0d valid=%b pend=%b ovr=%b, need all 0", code_fx, valid_fx, pend_fx, overrun_fx);
    end
    vec_count++;
    if ({code_rr, valid_rr, pend_rr, overrun_rr} !== 11'd0) begin
      err_count++;
      $display("[TB] FAIL mid_rst_rr: got code=%0d valid=%b pend=%b ovr=%b, need all 0", code_rr, valid_rr, pend_rr, overrun_rr);
    end
    // With last back at 3 the scan starts at line 0.
    req_rr = 4'b1111;
    tick();
    req_rr = 4'b0;
    tick();
    vec_count++;
    if (valid_rr !== 1'b1 || code_rr !== 2'd0) begin
      err_count++;
      $display("[TB] FAIL mid_restart: got valid=%b code=%0d, need 1/0", valid_rr, code_rr);
    end
  endtask

  initial begin
    $display("[TB] starting enc4x2_req_encoder bench");
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_clear_rerequest();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/enc4x2_req_encoder.md
# enc4x2_req_encoder

Registered 4-to-2 request encoder: the inverse of the team's 2x4 one-hot decoder. It collects pulses on four request lines into pending bits and presents one 2-bit index per transaction over a valid/ack handshake. It supports fixed or round-robin priority and flags overruns. It sits between four event sources and any consumer that takes a binary index, such as a 2x4 decoder driving per-line clear strobes.

## Interface
- `RR`, default 0: 0 = fixed priority (3 > 2 > 1 > 0); 1 = round-robin.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request pulses or levels; sampled every edge.
- `ack` input 1: consumer accepts the presented `code`; meaningful only while `valid`=1.
- `ovr_clr` input 1: clears all `overrun` bits.
- `code` output 2: index of the granted request line.
- `valid` output 1: `code` is presented and stable.
- `pend` output 4: current pending bits.
- `overrun` output 4: sticky per-line overrun flags.

## Operation
- Reset values: `code`=0, `valid`=0, `pend`=0, `overrun`=0, FSM=IDLE, RR pointer `last`=3.
- Pending update every edge: `pend <= (pend & ~clr_mask) | req`.
  - `clr_mask` is the one-hot of `code` when `valid && ack`; otherwise it is 0.
  - `req[i]` on the same edge as the clear of line i leaves `pend[i]`=1. This counts as a new event, not an overrun.
- Overrun:
  - `overrun[i]` is set when `req[i]`=1, `pend[i]`=1, and line i is not being cleared that edge.
  - `ovr_clr` zeroes all bits. If a new overrun coincides with `ovr_clr`, the set wins for that bit.
- FSM has two states, IDLE and PRESENT.
  - IDLE: if registered `pend`≠0, load `code` from the selector, set `valid`=1, go to PRESENT. Otherwise stay.
  - PRESENT: `code` and `valid` are held stable. On `ack`=1, clear the pending bit, set `valid`=0, go to IDLE. If RR=1, `last <= code`.
- Selector (combinational on registered `pend`):
  - RR=0: highest set index.
  - RR=1: first set index scanning ascending from `(last+1) mod 4`, wrapping 3→0. With a single pending bit, that index is chosen.
- `ack` while `valid`=0 is ignored and has no effect on `pend` or `last`.
- Requests arriving during PRESENT accumulate in `pend`. They never change the presented `code`.

## Timing
- Latency: `req[i]` high at edge N sets `pend[i]` after N. `valid`/`code` assert after edge N+1, giving 2 cycles from sampled request to presentation.
- Ack at edge M drops `valid` after M. The earliest next presentation is after M+1, so there is one idle cycle between grants. Throughput is 1 grant per 2 cycles minimum.
- Reset mid-operation: a `rst` edge overrides `ack`, `req` and `ovr_clr`. Every output returns to its reset value after that edge and the presented transaction is lost.
- Arithmetic: the RR pointer increment is 2-bit modulo; 3+1 wraps to 0.

## Structure
- Shared package holds:
  - `N_REQ`=4 and `CODE_W`=2
  - FSM state encoding, with IDLE=1'b0 and PRESENT=1'b1
  - the reset value of the RR pointer
- Sub-module `pri_enc4` is the combinational selector. Inputs are `pend[3:0]`, `start[1:0]` and `rr`. Outputs are `idx[1:0]` and `any`. The top holds only the registers and the FSM.

## Test plan
- Reset then idle: hold `rst` 2 cycles with `req`=4'b1111. After release all outputs = 0, and `req`=0 keeps `valid`=0.
- Fixed priority, RR=0: pulse `req`=4'b0101 for one cycle. `valid` after 2 edges with `code`=2. Ack gives `pend`=4'b0001. The next presentation is `code`=0 after 1 idle cycle, and the final ack gives `pend`=0.
- Round-robin, RR=1: hold `req`=4'b1111 constantly and ack each presentation. The code sequence is 0,1,2,3,0, with `overrun` bits set.
- Simultaneous clear and re-request: while `code`=1 is presented, assert `ack` and `req`=4'b0010 on the same edge. Required: `pend[1]` stays 1, `overrun`=0, and `code`=1 is re-presented after the idle cycle.
- Overrun priority and clear: set `pend[3]`, pulse `req[3]` again, and `overrun`=4'b1000. Asserting `ovr_clr` and `req[3]` together keeps `overrun[3]`=1. `ovr_clr` alone then gives 0.
- Reset mid-transaction: with `valid`=1, `code`=2, assert `rst` and `ack` on the same edge. Everything reads 0 after the edge, and `last`=3 on restart.
